// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_pkg
// Purpose  : Shared types and helpers for the 4-channel DMA controller.
//            Arbiter state encoding, priority-order type, the fixed-priority
//            default order and the rotating-priority update function.
// Revision : 1.0 - initial release
// ============================================================================
package dma_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    // One-hot arbiter state encoding.
    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        REQ   = 3'b010,
        GRANT = 3'b100
    } arb_state_t;

    // Field [0] holds the highest-priority channel, field [3] the lowest.
    typedef logic [3:0][1:0] priorityOrder_t;

    localparam priorityOrder_t DEFAULT_PRIORITY = 8'b11_10_01_00;

    // Rotate so that the channel after the one just serviced becomes highest.
    // The 2-bit sum wraps naturally, giving the mod-4 ring.
    function automatic priorityOrder_t rotate_priority(input logic [CH_W-1:0] served_ch);
        priorityOrder_t order;
        for (int k = 0; k < NUM_CH; k++) begin
            order[k] = served_ch + 2'(k + 1);
        end
        return order;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : dma_priority_encoder
// Purpose  : Combinational winner selection. Walks the priority order from
//            field 0 (highest) upward and returns the first channel whose
//            effective request is set.
// Ports    : eff_req        - qualified per-channel requests
//            priority_order - four 2-bit channel fields, [1:0] highest
//            winner         - selected channel index (0 when none)
//            valid          - at least one effective request present
// Revision : 1.0 - initial release
// ============================================================================
module dma_priority_encoder
    import dma_pkg::*;
(
    input  logic [3:0] eff_req,
    input  logic [7:0] priority_order,
    output logic [1:0] winner,
    output logic       valid
);

    priorityOrder_t w_order;
    assign w_order = priority_order;

    // Scan lowest priority first so the highest-priority match is written last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (eff_req[w_order[k]]) begin
                winner = w_order[k];
                valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dma_priority_arbiter
// Purpose  : Request/priority stage of the 4-channel DMA controller.
//            Qualifies DREQ, raises HRQ, picks a channel on HLDA by fixed or
//            rotating priority, and holds the grant until serviceDone.
// Ports    : CLK, RESET_N (sync, active-low)
//            DREQ, maskReg, priorityType, dreqSense, dackSense,
//            controllerDisable, HLDA, serviceDone  - inputs
//            HRQ, DACK, grantValid, grantCh, priorityOrder - outputs
// Revision : 1.0 - initial release
// ============================================================================
module dma_priority_arbiter
    import dma_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic              priorityType,
    input  logic              dreqSense,
    input  logic              dackSense,
    input  logic              controllerDisable,
    input  logic              HLDA,
    input  logic              serviceDone,
    output logic              HRQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              grantValid,
    output logic [CH_W-1:0]   grantCh,
    output logic [7:0]        priorityOrder
);

    arb_state_t      r_state;
    arb_state_t      w_next_state;
    logic [CH_W-1:0] r_grant_ch;
    logic [CH_W-1:0] w_next_grant_ch;
    priorityOrder_t  r_order;
    priorityOrder_t  w_next_order;

    logic [NUM_CH-1:0] w_eff_req;
    logic [CH_W-1:0]   w_win_ch;
    logic              w_win_valid;
    logic [NUM_CH-1:0] w_dack_active;

    assign w_eff_req = (DREQ ^ {NUM_CH{dreqSense}}) & ~maskReg
                       & {NUM_CH{~controllerDisable}};

    dma_priority_encoder u_encoder (
        .eff_req        (w_eff_req),
        .priority_order (r_order),
        .winner         (w_win_ch),
        .valid          (w_win_valid)
    );

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_state    <= IDLE;
            r_grant_ch <= '0;
            r_order    <= DEFAULT_PRIORITY;
        end else begin
            r_state    <= w_next_state;
            r_grant_ch <= w_next_grant_ch;
            r_order    <= w_next_order;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_grant_ch = r_grant_ch;
        // Fixed mode pins the order to the default every cycle, so leaving
        // rotating mode restores it on the next edge.
        w_next_order    = priorityType ? r_order : DEFAULT_PRIORITY;
        case (r_state)
            IDLE: begin
                if (|w_eff_req) begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                if (!w_win_valid) begin
                    w_next_state = IDLE;
                end else if (HLDA) begin
                    w_next_state    = GRANT;
                    w_next_grant_ch = w_win_ch;
                end
            end
            GRANT: begin
                // serviceDone wins over a simultaneous HLDA drop, so rotation
                // still happens; a plain bus loss leaves the order alone.
                if (serviceDone) begin
                    w_next_state = IDLE;
                    if (priorityType) begin
                        w_next_order = rotate_priority(r_grant_ch);
                    end
                end else if (!HLDA) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        w_dack_active = '0;
        if (r_state == GRANT) begin
            w_dack_active[r_grant_ch] = 1'b1;
        end
    end

    assign DACK          = w_dack_active ^ {NUM_CH{dackSense}};
    assign HRQ           = (r_state == REQ) || (r_state == GRANT);
    assign grantValid    = (r_state == GRANT);
    assign grantCh       = r_grant_ch;
    assign priorityOrder = r_order;

endmodule
`default_nettype wire

// File: tb/tb_dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_priority_arbiter
// Purpose  : Self-checking bench for dma_priority_arbiter: a table of single
//            arbitration vectors plus hand-written multi-cycle sequences for
//            rotation, withdrawal, bus loss and reset during a grant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_priority_arbiter;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] DREQ;
    logic [3:0] maskReg;
    logic       priorityType;
    logic       dreqSense;
    logic       dackSense;
    logic       controllerDisable;
    logic       HLDA;
    logic       serviceDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic       grantValid;
    logic [1:0] grantCh;
    logic [7:0] priorityOrder;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] dreq;
        logic [3:0] mask;
        logic       dreq_sense;
        logic       dack_sense;
        logic       ctrl_dis;
        logic       exp_hrq;
        logic [1:0] exp_ch;
        logic [3:0] exp_dack;
    } vec_t;

    vec_t vecs[10];

    dma_priority_arbiter dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .DREQ              (DREQ),
        .maskReg           (maskReg),
        .priorityType      (priorityType),
        .dreqSense         (dreqSense),
        .dackSense         (dackSense),
        .controllerDisable (controllerDisable),
        .HLDA              (HLDA),
        .serviceDone       (serviceDone),
        .HRQ               (HRQ),
        .DACK              (DACK),
        .grantValid        (grantValid),
        .grantCh           (grantCh),
        .priorityOrder     (priorityOrder)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RESET_N           = 1'b0;
        DREQ              = 4'b0000;
        maskReg           = 4'b0000;
        priorityType      = 1'b0;
        dreqSense         = 1'b0;
        dackSense         = 1'b0;
        controllerDisable = 1'b0;
        HLDA              = 1'b0;
        serviceDone       = 1'b0;
        step();
        step();
        RESET_N = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] idle_dack;

        //            dreq     mask     dS    kS    dis   hrq   ch    dack
        vecs[0] = '{4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001};
        vecs[1] = '{4'b1111, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100};
        vecs[2] = '{4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000};
        vecs[3] = '{4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010};
        vecs[4] = '{4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000};
        vecs[5] = '{4'b0101, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[6] = '{4'b1011, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 4'b1011};
        vecs[7] = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[8] = '{4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001};
        vecs[9] = '{4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 4'b1101};

        // Reset state
        do_reset();
        check("reset_hrq",   8'(HRQ),        8'd0);
        check("reset_gv",    8'(grantValid), 8'd0);
        check("reset_ch",    8'(grantCh),    8'd0);
        check("reset_dack",  8'(DACK),       8'd0);
        check("reset_order", priorityOrder,  8'b11_10_01_00);

        // Table of single arbitrations, fixed priority
        for (int i = 0; i < 10; i++) begin
            do_reset();
            DREQ              = vecs[i].dreq;
            maskReg           = vecs[i].mask;
            dreqSense         = vecs[i].dreq_sense;
            dackSense         = vecs[i].dack_sense;
            controllerDisable = vecs[i].ctrl_dis;
            idle_dack         = vecs[i].dack_sense ? 4'b1111 : 4'b0000;
            step();
            check($sformatf("v%0d_hrq", i), 8'(HRQ), 8'(vecs[i].exp_hrq));
            check($sformatf("v%0d_idle_dack", i), 8'(DACK), 8'(idle_dack));
            if (vecs[i].exp_hrq) begin
                HLDA = 1'b1;
                step();
                check($sformatf("v%0d_gv", i),   8'(grantValid), 8'd1);
                check($sformatf("v%0d_ch", i),   8'(grantCh),    8'(vecs[i].exp_ch));
                check($sformatf("v%0d_dack", i), 8'(DACK),       8'(vecs[i].exp_dack));
                serviceDone = 1'b1;
                step();
                serviceDone = 1'b0;
                HLDA        = 1'b0;
                check($sformatf("v%0d_done_hrq", i),  8'(HRQ),        8'd0);
                check($sformatf("v%0d_done_gv", i),   8'(grantValid), 8'd0);
                check($sformatf("v%0d_done_dack", i), 8'(DACK),       8'(idle_dack));
                check($sformatf("v%0d_order", i),     priorityOrder,  8'b11_10_01_00);
            end else begin
                step();
                check($sformatf("v%0d_still_idle", i), 8'(HRQ), 8'd0);
            end
        end

        // HLDA arrives two cycles after HRQ; DACK waits for it
        do_reset();
        DREQ = 4'b1111;
        step();
        check("late_hrq", 8'(HRQ), 8'd1);
        step();
        step();
        check("late_wait_dack", 8'(DACK),       8'd0);
        check("late_wait_gv",   8'(grantValid), 8'd0);
        HLDA = 1'b1;
        step();
        check("late_dack", 8'(DACK),    8'b0001);
        check("late_ch",   8'(grantCh), 8'd0);

        // Rotating priority: ch0, ch1, ch0 with DREQ = 0011 held
        do_reset();
        priorityType = 1'b1;
        DREQ         = 4'b0011;
        step();
        HLDA = 1'b1;
        step();
        check("rot1_ch", 8'(grantCh), 8'd0);
        serviceDone = 1'b1;
        step();
        serviceDone = 1'b0;
        check("rot1_order", priorityOrder, 8'b00_11_10_01);
        step();
        step();
        check("rot2_ch",   8'(grantCh), 8'd1);
        check("rot2_dack", 8'(DACK),    8'b0010);
        serviceDone = 1'b1;
        step();
        serviceDone = 1'b0;
        check("rot2_order", priorityOrder, 8'b01_00_11_10);
        step();
        step();
        check("rot3_ch", 8'(grantCh),    8'd0);
        check("rot3_gv", 8'(grantValid), 8'd1);

        // Reset while granted with a rotated order
        RESET_N = 1'b0;
        step();
        check("rstmid_hrq",   8'(HRQ),        8'd0);
        check("rstmid_dack",  8'(DACK),       8'd0);
        check("rstmid_gv",    8'(grantValid), 8'd0);
        check("rstmid_order", priorityOrder,  8'b11_10_01_00);
        RESET_N = 1'b1;

        // Leaving rotating mode restores the default order
        do_reset();
        priorityType = 1'b1;
        DREQ         = 4'b0001;
        step();
        HLDA = 1'b1;
        step();
        serviceDone = 1'b1;
        step();
        serviceDone = 1'b0;
        HLDA        = 1'b0;
        check("fixrest_rot", priorityOrder, 8'b00_11_10_01);
        priorityType = 1'b0;
        step();
        check("fixrest_default", priorityOrder, 8'b11_10_01_00);

        // Request withdrawn in REQ; HLDA afterwards in IDLE is ignored
        do_reset();
        DREQ = 4'b0001;
        step();
        check("wd_hrq", 8'(HRQ), 8'd1);
        DREQ = 4'b0000;
        step();
        check("wd_hrq_drop", 8'(HRQ),  8'd0);
        check("wd_dack",     8'(DACK), 8'd0);
        HLDA = 1'b1;
        step();
        check("wd_hlda_ignored", 8'(grantValid), 8'd0);

        // Grant survives DREQ drop and disable; bus loss keeps order
        do_reset();
        priorityType = 1'b1;
        DREQ         = 4'b0100;
        step();
        HLDA = 1'b1;
        step();
        check("bl_dack", 8'(DACK), 8'b0100);
        DREQ              = 4'b0000;
        controllerDisable = 1'b1;
        step();
        check("bl_hold_gv",   8'(grantValid), 8'd1);
        check("bl_hold_dack", 8'(DACK),       8'b0100);
        HLDA = 1'b0;
        step();
        check("bl_dack_drop", 8'(DACK),       8'd0);
        check("bl_hrq_drop",  8'(HRQ),        8'd0);
        check("bl_order",     priorityOrder,  8'b11_10_01_00);

        // serviceDone together with HLDA drop still rotates
        DREQ              = 4'b0100;
        controllerDisable = 1'b0;
        step();
        HLDA = 1'b1;
        step();
        check("both_ch", 8'(grantCh), 8'd2);
        HLDA        = 1'b0;
        serviceDone = 1'b1;
        step();
        serviceDone = 1'b0;
        check("both_order", priorityOrder, 8'b10_01_00_11);
        check("both_gv",    8'(grantValid), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
